// File: rtl/mor1kx_padv_sequencer_cappuccino.sv
// rtl/mor1kx_padv_sequencer_cappuccino.sv - pipeline advance/flush/debug-halt sequencer (debug halt gated by MOR1KX_PADV_DU_EN)
module mor1kx_padv_sequencer_cappuccino #(
    parameter int FLUSH_CYCLES    = 2,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid_i,
    input  logic                       decode_valid_i,
    input  logic                       execute_valid_i,
    input  logic                       ctrl_exception_i,
    input  logic                       ctrl_op_rfe_i,
    input  logic                       du_stall_req_i,
    input  logic                       du_restart_i,
    output logic                       padv_fetch_o,
    output logic                       padv_decode_o,
    output logic                       padv_execute_o,
    output logic                       padv_ctrl_o,
    output logic                       pipeline_flush_o,
    output logic                       du_stall_o,
    output logic [1:0]                 state_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DU_HALT = 2'd2,
        ST_RESUME  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic       flush_nxt, du_stall_nxt;
    logic       padv_front, padv_rest;
    logic       du_req, du_restart, adv, redirect;

`ifdef MOR1KX_PADV_DU_EN
    assign du_req     = du_stall_req_i;
    assign du_restart = du_restart_i;
`else
    logic unused_du;
    assign unused_du  = du_stall_req_i | du_restart_i;
    assign du_req     = 1'b0;
    assign du_restart = 1'b0;
`endif

    assign adv      = fetch_valid_i & decode_valid_i & execute_valid_i;
    assign redirect = ctrl_exception_i | ctrl_op_rfe_i;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        flush_nxt     = 1'b0;
        du_stall_nxt  = 1'b0;
        padv_front    = 1'b0;
        padv_rest     = 1'b0;
        case (state)
            ST_RUN: begin
                padv_front = adv & ~redirect & ~du_req;
                padv_rest  = padv_front;
                if (redirect) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                    flush_nxt     = 1'b1;
                end else if (du_req) begin
                    state_nxt    = ST_DU_HALT;
                    flush_nxt    = 1'b1;
                    du_stall_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    flush_nxt     = 1'b1;
                end
            end
            ST_DU_HALT: begin
                // Flush only on entry; afterwards du_stall_o alone holds the tail registers.
                if (du_restart) state_nxt = ST_RESUME;
                else            du_stall_nxt = 1'b1;
            end
            ST_RESUME: begin
                padv_front = fetch_valid_i;
                state_nxt  = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign padv_fetch_o   = padv_front & ~rst;
    assign padv_decode_o  = padv_rest & ~rst;
    assign padv_execute_o = padv_rest & ~rst;
    assign padv_ctrl_o    = padv_rest & ~rst;
    assign state_o        = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_RUN;
            flush_cnt        <= 4'd0;
            pipeline_flush_o <= 1'b0;
            du_stall_o       <= 1'b0;
            stall_cycles_o   <= '0;
        end else begin
            state            <= state_nxt;
            flush_cnt        <= flush_cnt_nxt;
            pipeline_flush_o <= flush_nxt;
            du_stall_o       <= du_stall_nxt;
            if (state == ST_RUN && !padv_execute_o && stall_cycles_o != '1)
                stall_cycles_o <= stall_cycles_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mor1kx_padv_sequencer_cappuccino.sv
// tb/tb_mor1kx_padv_sequencer_cappuccino.sv - scoreboard bench for the padv sequencer
module tb_mor1kx_padv_sequencer_cappuccino;

    localparam int FC  = 2;
    localparam int W   = 4;
    localparam int SAT = (1 << W) - 1;
`ifdef MOR1KX_PADV_DU_EN
    localparam bit DU_EN = 1'b1;
`else
    localparam bit DU_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fv = 0, dv = 0, ev = 0, exc = 0, rfe = 0, dreq = 0, drst = 0;
    logic         p_f, p_d, p_e, p_c, flush, du;
    logic [1:0]   st;
    logic [W-1:0] stall;

    mor1kx_padv_sequencer_cappuccino #(.FLUSH_CYCLES(FC), .STALL_CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fv), .decode_valid_i(dv), .execute_valid_i(ev),
        .ctrl_exception_i(exc), .ctrl_op_rfe_i(rfe),
        .du_stall_req_i(dreq), .du_restart_i(drst),
        .padv_fetch_o(p_f), .padv_decode_o(p_d), .padv_execute_o(p_e), .padv_ctrl_o(p_c),
        .pipeline_flush_o(flush), .du_stall_o(du), .state_o(st), .stall_cycles_o(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] padv;   // {ctrl, execute, decode, fetch}
        logic       flush;
        logic       du;
        int         st;
        int         stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 run, 1 flushing, 2 halted, 3 resuming
    int   m_state = 0;
    int   m_flush_left = 0;
    bit   m_halt_first = 0;
    int   m_stall = 0;
    bit   m_known = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit f, input bit d, input bit e_v,
                         input bit x, input bit rf, input bit q, input bit rs);
        exp_t e;
        bit   ok, dq, dr;
        @(negedge clk);
        rst = r; fv = f; dv = d; ev = e_v; exc = x; rfe = rf; dreq = q; drst = rs;
        dq = DU_EN && q;
        dr = DU_EN && rs;
        ok = 0;
        e.st    = m_state;
        e.stall = m_stall;
        e.du    = (m_state == 2);
        e.flush = (m_state == 1) || (m_state == 2 && m_halt_first);
        e.padv  = 4'b0000;
        if (!r) begin
            if (m_state == 0) begin
                ok = f && d && e_v && !x && !rf && !dq;
                e.padv = ok ? 4'b1111 : 4'b0000;
            end else if (m_state == 3) begin
                e.padv = {3'b000, f};
            end
        end
        if (m_known) exp_q.push_back(e);
        if (r) begin
            m_state = 0; m_flush_left = 0; m_halt_first = 0; m_stall = 0; m_known = 1;
        end else begin
            case (m_state)
                0: begin
                    if (!ok) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
                    if (x || rf) begin
                        m_state = 1; m_flush_left = FC;
                    end else if (dq) begin
                        m_state = 2; m_halt_first = 1;
                    end
                end
                1: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_state = 0;
                end
                2: begin
                    m_halt_first = 0;
                    if (dr) m_state = 3;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("padv_fetch",   int'(p_f), int'(e.padv[0]));
                chk("padv_decode",  int'(p_d), int'(e.padv[1]));
                chk("padv_execute", int'(p_e), int'(e.padv[2]));
                chk("padv_ctrl",    int'(p_c), int'(e.padv[3]));
                chk("pipeline_flush", int'(flush), int'(e.flush));
                chk("du_stall",     int'(du), int'(e.du));
                chk("state",        int'(st), e.st);
                chk("stall_cycles", int'(stall), e.stall);
            end
        end
    end

    initial begin
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) cycle(0, 1, 1, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 1, 0, 0, 0);
        repeat (4) cycle(0, 1, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 1, 0, 0);
        repeat (3) cycle(0, 1, 1, 1, 0, 0, 0, 0);
        repeat (20) cycle(0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 1, 0, 1, 0);
        repeat (4) cycle(0, 1, 1, 1, 0, 0, 1, 0);
        cycle(0, 1, 1, 1, 0, 0, 0, 1);
        repeat (3) cycle(0, 1, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 1, 1);
        cycle(0, 1, 1, 1, 0, 0, 0, 1);
        repeat (3) cycle(0, 1, 1, 1, 0, 0, 1, 0);
        cycle(0, 1, 1, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        #5;
        chk("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
